// File: rtl/frame_sched_pkg.sv
// Shared definitions for the per-frame update scheduler: FSM states and default timing constants.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } sched_state_t;

  localparam int VACTIVE_DEF = 480;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/frame_update_scheduler_vblank.sv
// Vertical-blank edge detector: compares DrawY against the first non-visible line and flags entry/exit.
module vblank_edge_detect
  import frame_sched_pkg::*;
#(
  parameter int VACTIVE = VACTIVE_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawY,
  output logic       vb_rise,
  output logic       vb_fall
);

  logic in_vblank_d;
  logic in_vblank_q;

  always_comb begin
    in_vblank_d = (DrawY >= 10'(VACTIVE));
  end

  // Resetting to "in vblank" makes a release mid-vblank wait for the next full vblank.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) in_vblank_q <= 1'b1;
    else       in_vblank_q <= in_vblank_d;
  end

  assign vb_rise = in_vblank_d & ~in_vblank_q;
  assign vb_fall = ~in_vblank_d & in_vblank_q;

endmodule

// File: rtl/frame_update_scheduler.sv
// Grants each game-state update client one exclusive turn per vblank, then pulses commit so the
// display registers only change while the beam is off-screen.
module frame_update_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int VACTIVE     = VACTIVE_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int TW          = $clog2(TIMEOUT)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawY,
  input  logic [NUM_CLIENTS-1:0] done,
  input  logic                   clear_err,
  output logic [NUM_CLIENTS-1:0] start,
  output logic                   busy,
  output logic                   commit,
  output logic                   overrun,
  output logic [NUM_CLIENTS-1:0] timeout_err,
  output logic [7:0]             frame_count
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CLIENTS - 1);
  localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT - 1);

  logic vb_rise;
  logic vb_fall;

  vblank_edge_detect #(.VACTIVE(VACTIVE)) u_vblank (
    .Clk     (Clk),
    .Reset   (Reset),
    .DrawY   (DrawY),
    .vb_rise (vb_rise),
    .vb_fall (vb_fall)
  );

  sched_state_t           state_d, state_q;
  logic [IW-1:0]          idx_d, idx_q;
  logic [TW-1:0]          timer_d, timer_q;
  logic [NUM_CLIENTS-1:0] start_d, start_q;
  logic                   busy_d, busy_q;
  logic                   commit_d, commit_q;
  logic                   overrun_d, overrun_q;
  logic [NUM_CLIENTS-1:0] timeout_err_d, timeout_err_q;
  logic [7:0]             frame_count_d, frame_count_q;
  logic                   complete;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    start_d       = '0;
    commit_d      = 1'b0;
    frame_count_d = frame_count_q;
    overrun_d     = clear_err ? 1'b0 : overrun_q;
    timeout_err_d = clear_err ? '0 : timeout_err_q;
    complete      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vb_rise) begin
          state_d = ISSUE;
          idx_d   = '0;
          timer_d = '0;
          start_d = NUM_CLIENTS'(1);
        end
      end
      ISSUE: begin
        if (vb_fall) begin
          state_d   = IDLE;
          idx_d     = '0;
          overrun_d = 1'b1;
        end else begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        // Losing vblank beats any completion arriving in the same cycle.
        if (vb_fall) begin
          state_d   = IDLE;
          idx_d     = '0;
          overrun_d = 1'b1;
        end else begin
          if (done[idx_q]) begin
            complete = 1'b1;
          end else if (timer_q == TIMER_LIM) begin
            complete             = 1'b1;
            timeout_err_d[idx_q] = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
          if (complete) begin
            if (idx_q == LAST_IDX) begin
              state_d       = COMMIT;
              commit_d      = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
            end else begin
              state_d = ISSUE;
              idx_d   = idx_q + 1'b1;
              start_d = NUM_CLIENTS'(1) << idx_d;
            end
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      start_q       <= '0;
      busy_q        <= 1'b0;
      commit_q      <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      commit_q      <= commit_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign commit      = commit_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences the per-frame game-state updates for the Pong datapath so display registers change only during vertical blanking.
- Watches DrawY from the VGA timing generator and detects the start of vblank (DrawY >= VACTIVE).
- Grants each update client (ball, paddle L, paddle R, score) one exclusive turn, in fixed index order, using a start/done handshake.
- Emits a single commit pulse once all clients have finished, which latches the new positions into the display registers. Flags timeouts and vblank overruns.

Parameters:
- NUM_CLIENTS, 4, number of update clients; index 0 is served first.
- VACTIVE, 480, first non-visible line; the block is in vblank while DrawY >= VACTIVE.
- TIMEOUT, 1024, maximum number of WAIT cycles allowed per client.
- TW, $clog2(TIMEOUT), width of the timeout counter.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high
- DrawY  in  10  current vertical line from the VGA timing generator
- done  in  NUM_CLIENTS  client i has finished its update; 1-cycle pulse or level
- clear_err  in  1  synchronous clear of the sticky error flags
- start  out  NUM_CLIENTS  one-hot, 1-cycle pulse granting client i its turn
- busy  out  1  high while the state is not IDLE
- commit  out  1  1-cycle pulse; all clients have completed this frame
- overrun  out  1  sticky; vblank ended before the commit
- timeout_err  out  NUM_CLIENTS  sticky per-client timeout flags
- frame_count  out  8  count of committed frames, wraps 255 -> 0

Behaviour:
- Reset values: start=0, busy=0, commit=0, overrun=0, timeout_err=0, frame_count=0, state=IDLE, idx=0, timer=0, in_vblank_q=1.
  - in_vblank_q resets to 1 so that a reset released mid-vblank waits for the next full vblank.
- Vblank detect: in_vblank = (DrawY >= VACTIVE).
  - in_vblank_q is updated from in_vblank every Clk.
  - vb_rise = in_vblank & ~in_vblank_q.
  - vb_fall = ~in_vblank & in_vblank_q.
- All outputs are registered.
- States:
  - IDLE: on vb_rise, go to ISSUE with idx=0. All other conditions hold IDLE.
  - ISSUE: start[idx]=1 for exactly this cycle; timer cleared; go to WAIT.
  - WAIT: timer increments each cycle. done is sampled only here, and only done[idx] counts.
    - done[idx]=1: the client is complete.
    - else if timer==TIMEOUT-1: set timeout_err[idx]; the client is treated as complete.
    - On completion: if idx==NUM_CLIENTS-1, go to COMMIT; otherwise idx+1, go to ISSUE.
  - COMMIT: commit=1 for one cycle; frame_count+1 (modulo 256); idx=0; go to IDLE.
- Latency: vb_rise seen in IDLE at cycle t gives start[0] at t+1 and WAIT from t+2.
  - done[idx] at cycle c gives the next start at c+1, or commit at c+1 after the last client.
  - Minimum frame sequence: 2*NUM_CLIENTS+1 cycles after vb_rise.
- Priority, highest first: Reset > vb_fall abort > done > timeout.
  - vb_fall while in ISSUE or WAIT: set overrun; go to IDLE; start=0; no commit; frame_count unchanged; idx=0.
  - vb_fall in the same cycle as the COMMIT state: the commit still completes; no overrun.
  - done[idx] in the same cycle that the timer reaches its limit: done wins; no timeout_err.
  - done on any non-current index is ignored, and is never remembered for a later turn.
- clear_err=1 clears overrun and timeout_err next cycle. A set request in the same cycle wins over the clear.
- vb_rise outside IDLE cannot occur with legal VGA timing and is ignored.
- Reset asserted mid-sequence aborts immediately. No commit and no start are issued until the next vb_rise after release.

Decomposition:
- Shared package frame_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, COMMIT);
  - the constants VACTIVE_DEF=480 and TIMEOUT_DEF=1024.
- Natural sub-module: vblank_edge_detect, covering the DrawY compare, the in_vblank_q register, and the vb_rise/vb_fall outputs. Reset value of in_vblank_q is 1.
- FSM, index counter, timeout timer and sticky flags stay in the top module.

Test Plan:
- Normal frame: DrawY steps 479->480 with each client answering done 3 cycles after its start.
  - Expect start 0b0001, 0b0010, 0b0100, 0b1000 in turn.
  - commit at vb_rise+17 (vb_rise = first cycle DrawY=480 is seen); frame_count 0->1; busy high for cycles t+1..t+17.
- Timeout: client 2 never asserts done, TIMEOUT=16.
  - timeout_err=0b0100 after 16 WAIT cycles; start[3] follows; commit still occurs.
- Overrun: client 1 silent, TIMEOUT=1024, DrawY goes 524->0 during WAIT.
  - overrun=1, no commit, frame_count unchanged, busy=0 next cycle.
  - The following vblank restarts at client 0.
- Collision/ignore: done[3] pulsed while client 0 is current.
  - Ignored; later client 3 waits for its own done.
  - done[idx] arriving on the timer-limit cycle leaves timeout_err unchanged.
- Reset mid-WAIT, released while DrawY=500: no start until DrawY goes 524->0->...->480; counters and flags are zero.
- frame_count wrap: run 256 frames, expect 255->0. clear_err after an error clears all sticky flags.
